// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-key push-button synchroniser, debouncer and press/release/long event generator
//
// Purpose:
//   Each key passes through a 2-FF synchroniser and a counter debouncer. A
//   per-key FSM (IDLE/HELD/LONG) then turns the clean level into single-cycle
//   press, release and long-press pulses. All keys are fully independent.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   btn_raw      in   N_BTN  raw key inputs, 1 = pressed, asynchronous to clk
//   btn_level    out  N_BTN  debounced key level
//   btn_press    out  N_BTN  1-cycle pulse on accepted press (and on auto-repeat)
//   btn_release  out  N_BTN  1-cycle pulse on accepted release
//   btn_long     out  N_BTN  1-cycle pulse after LONG_CNT cycles held, once per press
//
// Configuration macro:
//   BTN_AUTOREPEAT_EN - when defined, btn_press also pulses every REPEAT_CNT
//                       cycles while a key stays in the LONG state.

module btn_conditioner #(
    parameter int N_BTN      = 4,
    parameter int DB_CNT     = 10,
    parameter int LONG_CNT   = 1000,
    parameter int REPEAT_CNT = 200,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

    // Every counter shares CNT_W, so it must cover the largest terminal count.
    localparam int MAX_CNT = (DB_CNT > LONG_CNT)
                           ? ((DB_CNT > REPEAT_CNT) ? DB_CNT : REPEAT_CNT)
                           : ((LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT);

    if (MAX_CNT >= (1 << CNT_W)) begin : g_cnt_w_too_small
        $error("btn_conditioner: CNT_W too small for DB_CNT/LONG_CNT/REPEAT_CNT");
    end
    if (DB_CNT < 2) begin : g_db_cnt_too_small
        $error("btn_conditioner: DB_CNT must be at least 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_key
        logic [1:0]       r_sync;
        logic [CNT_W-1:0] r_db_cnt;
        logic [CNT_W-1:0] r_hold_cnt;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic             r_long;
        state_t           r_state;
        logic             w_s;
        logic             w_accept;
`ifdef BTN_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CNT - 1);
        logic [CNT_W-1:0] r_rep_cnt;
`endif

        assign w_s      = r_sync[1];
        // A change is accepted on the DB_CNT-th consecutive differing cycle.
        assign w_accept = (w_s != r_level) && (r_db_cnt == DB_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync     <= 2'b00;
                r_db_cnt   <= '0;
                r_hold_cnt <= '0;
                r_level    <= 1'b0;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_long     <= 1'b0;
                r_state    <= S_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                r_rep_cnt  <= '0;
`endif
            end else begin
                r_sync    <= {r_sync[0], btn_raw[i]};
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;

                if (w_s == r_level) begin
                    r_db_cnt <= '0;
                end else if (!w_accept) begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end

                // An accepted level change outranks long/repeat events so the
                // three pulses can never coincide on one key.
                if (w_accept) begin
                    r_db_cnt   <= '0;
                    r_level    <= w_s;
                    r_hold_cnt <= '0;
`ifdef BTN_AUTOREPEAT_EN
                    r_rep_cnt  <= '0;
`endif
                    if (w_s) begin
                        r_press <= 1'b1;
                        r_state <= S_HELD;
                    end else begin
                        r_release <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end else begin
                    case (r_state)
                        S_HELD: begin
                            if (r_hold_cnt == LONG_LAST) begin
                                r_long  <= 1'b1;
                                r_state <= S_LONG;
`ifdef BTN_AUTOREPEAT_EN
                                r_rep_cnt <= '0;
`endif
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 1'b1;
                            end
                        end
                        S_LONG: begin
`ifdef BTN_AUTOREPEAT_EN
                            if (r_rep_cnt == REP_LAST) begin
                                r_press   <= 1'b1;
                                r_rep_cnt <= '0;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
        assign btn_long[i]    = r_long;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
module tb_btn_conditioner;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    int n_chk = 0;
    int n_bad = 0;
    int cnt_press   [N];
    int cnt_release [N];
    int cnt_long    [N];
    int excl_bad = 0;

    btn_conditioner #(
        .N_BTN(4), .DB_CNT(4), .LONG_CNT(20), .REPEAT_CNT(5), .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    // Pulse counting and exclusivity watch, sampled on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            cnt_press[k]   += int'(btn_press[k]);
            cnt_release[k] += int'(btn_release[k]);
            cnt_long[k]    += int'(btn_long[k]);
            if ((int'(btn_press[k]) + int'(btn_release[k]) + int'(btn_long[k])) > 1)
                excl_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_counts();
        for (int k = 0; k < N; k++) begin
            cnt_press[k] = 0;
            cnt_release[k] = 0;
            cnt_long[k] = 0;
        end
    endtask

    initial begin
        int exp_rep_press;
`ifdef BTN_AUTOREPEAT_EN
        exp_rep_press = 4;
`else
        exp_rep_press = 1;
`endif
        clr_counts();

        // 1. reset with all keys held
        btn_raw = 4'b1111;
        tick(3);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_pulses", 32'({btn_press, btn_release, btn_long}), 32'h0);
        rst = 1'b0;
        tick(5);
        check("rst_rel_level_early", 32'(btn_level), 32'h0);
        tick(1);
        check("rst_rel_level", 32'(btn_level), 32'hf);
        check("rst_rel_press", 32'(btn_press), 32'hf);
        tick(1);
        check("rst_rel_press_gone", 32'(btn_press), 32'h0);
        btn_raw = 4'b0000;
        tick(6);
        check("all_release", 32'(btn_release), 32'hf);
        tick(2);

        // 2. clean press on key 3
        clr_counts();
        btn_raw[3] = 1'b1;
        tick(5);
        check("k3_level_early", 32'(btn_level[3]), 32'h0);
        tick(1);
        check("k3_level", 32'(btn_level[3]), 32'h1);
        check("k3_press", 32'(btn_press), 32'h8);
        tick(4);
        btn_raw[3] = 1'b0;
        tick(5);
        check("k3_level_hold", 32'(btn_level[3]), 32'h1);
        tick(1);
        check("k3_release", 32'(btn_release), 32'h8);
        tick(2);
        check("k3_press_cnt", 32'(cnt_press[3]), 32'd1);
        check("k3_release_cnt", 32'(cnt_release[3]), 32'd1);
        check("k3_no_long", 32'(cnt_long[3]), 32'd0);

        // 3. bounce on key 1, then a short glitch
        clr_counts();
        for (int b = 0; b < 4; b++) begin
            btn_raw[1] = ~b[0];
            tick(2);
        end
        btn_raw[1] = 1'b1;
        tick(5);
        check("k1_bounce_level_early", 32'(btn_level[1]), 32'h0);
        tick(1);
        check("k1_bounce_level", 32'(btn_level[1]), 32'h1);
        check("k1_bounce_press", 32'(btn_press), 32'h2);
        btn_raw[1] = 1'b0;
        tick(8);
        btn_raw[1] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b0;
        tick(10);
        check("k1_glitch_level", 32'(btn_level[1]), 32'h0);
        check("k1_press_cnt", 32'(cnt_press[1]), 32'd1);
        check("k1_release_cnt", 32'(cnt_release[1]), 32'd1);

        // 4. long press on key 2, then a short hold
        clr_counts();
        btn_raw[2] = 1'b1;
        tick(6);
        check("k2_press", 32'(btn_press), 32'h4);
        tick(19);
        check("k2_long_early", 32'(btn_long), 32'h0);
        tick(1);
        check("k2_long", 32'(btn_long), 32'h4);
        tick(14);
        btn_raw[2] = 1'b0;
        tick(8);
        check("k2_long_cnt", 32'(cnt_long[2]), 32'd1);
        check("k2_press_cnt", 32'(cnt_press[2]), 32'(exp_rep_press));
        btn_raw[2] = 1'b1;
        tick(15);
        btn_raw[2] = 1'b0;
        tick(10);
        check("k2_short_no_long", 32'(cnt_long[2]), 32'd1);
        check("k2_short_level", 32'(btn_level[2]), 32'h0);

        // 5. auto-repeat behaviour on key 0
        clr_counts();
        btn_raw[0] = 1'b1;
        tick(6);
        check("k0_press", 32'(btn_press), 32'h1);
        tick(20);
        check("k0_long", 32'(btn_long), 32'h1);
        tick(4);
        check("k0_rep_early", 32'(btn_press), 32'h0);
        tick(1);
`ifdef BTN_AUTOREPEAT_EN
        check("k0_rep_first", 32'(btn_press), 32'h1);
`else
        check("k0_rep_first", 32'(btn_press), 32'h0);
`endif
        tick(9);
        btn_raw[0] = 1'b0;
        tick(8);
        check("k0_press_cnt", 32'(cnt_press[0]), 32'(exp_rep_press));
        check("k0_release_cnt", 32'(cnt_release[0]), 32'd1);

        // 6. simultaneous keys and reset mid-hold
        clr_counts();
        btn_raw = 4'b1001;
        tick(6);
        check("k30_press", 32'(btn_press), 32'h9);
        check("k30_level", 32'(btn_level), 32'h9);
        tick(3);
        rst = 1'b1;
        #1;
        check("midrst_level", 32'(btn_level), 32'h0);
        check("midrst_pulses", 32'({btn_press, btn_release, btn_long}), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(6);
        check("post_rst_press", 32'(btn_press), 32'h9);
        check("midrst_no_release", 32'(cnt_release[0] + cnt_release[3]), 32'd0);
        btn_raw = 4'b0000;
        tick(8);
        check("final_release", 32'(cnt_release[0] + cnt_release[3]), 32'd2);
        check("exclusive", 32'(excl_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
